// File: rtl/n3l_pair_scheduler.sv
// Candidate-pair sequencer for one (reference cell, neighbor cell) job: walks every
// (i, j) pair, filters it through n3l, and streams out only the accepted pairs.

module n3l (
  input  logic [95:0] ref_pos,
  input  logic [95:0] nbr_pos,
  output logic        o
);
  logic signed [31:0] dx, dy, dz;

  assign dx = nbr_pos[31:0]  - ref_pos[31:0];
  assign dy = nbr_pos[63:32] - ref_pos[63:32];
  assign dz = nbr_pos[95:64] - ref_pos[95:64];

  // 0x8000_0000 has zero magnitude below the sign bit and is treated as forward
  function automatic logic fwd(input logic signed [31:0] d);
    return !(d[31] && (d[30:0] != '0));
  endfunction

  always_comb begin
    o = 1'b0;
    if (dx != '0)      o = fwd(dx);
    else if (dy != '0) o = fwd(dy);
    else if (dz != '0) o = fwd(dz);
  end
endmodule

module n3l_pair_scheduler #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   ref_count,
  input  logic [ADDR_W:0]   nbr_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ref_addr,
  input  logic [95:0]       ref_data,
  output logic [ADDR_W-1:0] nbr_addr,
  input  logic [95:0]       nbr_data,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [95:0]       pair_ref,
  output logic [95:0]       pair_nbr,
  output logic [ADDR_W-1:0] pair_ref_idx,
  output logic [ADDR_W-1:0] pair_nbr_idx,
  output logic [2*ADDR_W:0] pass_count
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EVAL, S_EMIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ref_idx, nbr_idx;
  logic [ADDR_W:0]     ref_cnt_r, nbr_cnt_r;
  logic [95:0]         pair_ref_r, pair_nbr_r;
  logic [ADDR_W-1:0]   pair_ref_idx_r, pair_nbr_idx_r;
  logic [2*ADDR_W:0]   pass_q;
  logic                load, capture, advance;
  logic                ref_last, nbr_last, last_cand;
  logic                filt_o;

  n3l u_n3l (
    .ref_pos (ref_data),
    .nbr_pos (nbr_data),
    .o       (filt_o)
  );

  assign ref_last  = ({1'b0, ref_idx} == (ref_cnt_r - (ADDR_W+1)'(1)));
  assign nbr_last  = ({1'b0, nbr_idx} == (nbr_cnt_r - (ADDR_W+1)'(1)));
  assign last_cand = ref_last && nbr_last;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ((ref_count == '0) || (nbr_count == '0)) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_EVAL;
      S_EVAL: begin
        if (filt_o) begin
          capture = 1'b1;
          state_d = S_EMIT;
        end else if (last_cand) begin
          state_d = S_DONE;
        end else begin
          advance = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EMIT: begin
        if (pair_ready) begin
          if (last_cand) begin
            state_d = S_DONE;
          end else begin
            advance = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ref_idx        <= '0;
      nbr_idx        <= '0;
      ref_cnt_r      <= '0;
      nbr_cnt_r      <= '0;
      pair_ref_r     <= '0;
      pair_nbr_r     <= '0;
      pair_ref_idx_r <= '0;
      pair_nbr_idx_r <= '0;
      pass_q         <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        ref_cnt_r <= ref_count;
        nbr_cnt_r <= nbr_count;
        ref_idx   <= '0;
        nbr_idx   <= '0;
        pass_q    <= '0;
      end
      // neighbor index is the inner loop, reference index the outer loop
      if (advance) begin
        if (nbr_last) begin
          nbr_idx <= '0;
          ref_idx <= ref_idx + ADDR_W'(1);
        end else begin
          nbr_idx <= nbr_idx + ADDR_W'(1);
        end
      end
      if (capture) begin
        pair_ref_r     <= ref_data;
        pair_nbr_r     <= nbr_data;
        pair_ref_idx_r <= ref_idx;
        pair_nbr_idx_r <= nbr_idx;
        pass_q         <= pass_q + (2*ADDR_W+1)'(1);
      end
    end
  end

  assign busy         = (state_q == S_FETCH) || (state_q == S_EVAL) || (state_q == S_EMIT);
  assign done         = (state_q == S_DONE);
  assign pair_valid   = (state_q == S_EMIT);
  assign ref_addr     = ref_idx;
  assign nbr_addr     = nbr_idx;
  assign pair_ref     = pair_ref_r;
  assign pair_nbr     = pair_nbr_r;
  assign pair_ref_idx = pair_ref_idx_r;
  assign pair_nbr_idx = pair_nbr_idx_r;
  assign pass_count   = pass_q;
endmodule

// File: tb/tb_n3l_pair_scheduler.sv
// Bench for n3l_pair_scheduler: directed jobs plus random jobs compared against a
// timeline model built from the candidate-walk and filter rules.

module tb_n3l_pair_scheduler;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, pair_ready;
  logic [AW:0]   ref_count, nbr_count;
  logic          busy, done, pair_valid;
  logic [AW-1:0] ref_addr, nbr_addr, pair_ref_idx, pair_nbr_idx;
  logic [95:0]   ref_data, nbr_data, pair_ref, pair_nbr;
  logic [2*AW:0] pass_count;

  logic [95:0] ref_mem [0:255];
  logic [95:0] nbr_mem [0:255];

  typedef struct {int i; int j; int cyc;} pr_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  n3l_pair_scheduler #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ref_count(ref_count), .nbr_count(nbr_count),
    .busy(busy), .done(done),
    .ref_addr(ref_addr), .ref_data(ref_data),
    .nbr_addr(nbr_addr), .nbr_data(nbr_data),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_ref(pair_ref), .pair_nbr(pair_nbr),
    .pair_ref_idx(pair_ref_idx), .pair_nbr_idx(pair_nbr_idx),
    .pass_count(pass_count)
  );

  always @(posedge clk) begin
    ref_data <= ref_mem[ref_addr];
    nbr_data <= nbr_mem[nbr_addr];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] pos(input int x, input int y, input int z);
    logic [31:0] xx, yy, zz;
    xx = x; yy = y; zz = z;
    return {zz, yy, xx};
  endfunction

  // Filter rule: first nonzero component of (b - a) decides; strictly negative
  // values reject, 0x8000_0000 and positive values accept, all-zero rejects.
  function automatic bit accept(input logic [95:0] a, input logic [95:0] b);
    logic [31:0] d;
    for (int c = 0; c < 3; c++) begin
      d = b[32*c +: 32] - a[32*c +: 32];
      if (d != 0) return (d == 32'h8000_0000) || ($signed(d) > 0);
    end
    return 1'b0;
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) begin
      ref_mem[a] = '0;
      nbr_mem[a] = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; pair_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // rmode: 0 ready always, 1 ready low in cycles 5..8, 2 random ready.
  task automatic run_job(input string tag, input int r, input int n, input int rmode,
                         input int rst_cyc, input int xs_cyc);
    bit          rdy [0:4095];
    pr_t         expq[$];
    int          t, k, done_exp, done_obs, maxc;
    bit          busy_seen, hold;
    logic [95:0] s_ref, s_nbr;
    logic [AW-1:0] s_ri, s_ni;

    for (int c = 0; c < 4096; c++)
      rdy[c] = (rmode == 0) ? 1'b1 : (rmode == 1) ? !(c >= 5 && c <= 8) : ($urandom_range(0, 3) != 0);

    t = 1;
    if (r == 0 || n == 0) done_exp = 1;
    else begin
      for (int i = 0; i < r; i++)
        for (int j = 0; j < n; j++) begin
          t += 2;
          if (accept(ref_mem[i], nbr_mem[j])) begin
            while (!rdy[t] && t < 4095) t++;
            expq.push_back('{i, j, t});
            t++;
          end
        end
      done_exp = t;
    end

    maxc = done_exp + 20;
    k = 0; done_obs = -1; busy_seen = 0; hold = 0;
    s_ref = '0; s_nbr = '0; s_ri = '0; s_ni = '0;
    for (int c = 0; c <= maxc; c++) begin
      @(posedge clk); #1;
      start      = (c == 0) || (c == xs_cyc);
      ref_count  = (c == xs_cyc) ? '0 : (AW+1)'(r);
      nbr_count  = (AW+1)'(n);
      pair_ready = rdy[c];
      rst        = (c == rst_cyc);
      @(negedge clk);
      if (hold) begin
        chk({tag, " hold valid"}, pair_valid, 1'b1);
        chk({tag, " hold data"}, {pair_ref, pair_nbr, pair_ref_idx, pair_nbr_idx},
            {s_ref, s_nbr, s_ri, s_ni});
        hold = 0;
      end
      if (busy) busy_seen = 1;
      if (rst_cyc >= 0 && c == rst_cyc) chk({tag, " valid before rst"}, pair_valid, 1'b1);
      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        chk({tag, " rst valid"}, pair_valid, 1'b0);
        chk({tag, " rst busy"}, busy, 1'b0);
        chk({tag, " rst done"}, done, 1'b0);
        chk({tag, " rst pass"}, pass_count, '0);
        chk({tag, " rst data"}, {pair_ref, pair_nbr, ref_addr, nbr_addr}, '0);
        break;
      end
      if (pair_valid && c != rst_cyc) begin
        if (pair_ready) begin
          if (k < expq.size()) begin
            chk({tag, " pair idx"}, {pair_ref_idx, pair_nbr_idx},
                {AW'(expq[k].i), AW'(expq[k].j)});
            chk({tag, " pair pos"}, {pair_ref, pair_nbr},
                {ref_mem[expq[k].i], nbr_mem[expq[k].j]});
            chk({tag, " pair cycle"}, c, expq[k].cyc);
          end else chk({tag, " extra pair"}, 1, 0);
          k++;
        end else begin
          hold = 1;
          s_ref = pair_ref; s_nbr = pair_nbr; s_ri = pair_ref_idx; s_ni = pair_nbr_idx;
        end
      end
      if (done) begin
        done_obs = c;
        break;
      end
    end

    if (rst_cyc < 0) begin
      chk({tag, " done cycle"}, done_obs, done_exp);
      chk({tag, " pair count"}, k, expq.size());
      chk({tag, " pass_count"}, pass_count, expq.size());
      chk({tag, " busy seen"}, busy_seen, (r != 0 && n != 0));
      if (done_obs < 0) do_reset();
      else begin
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, " done pulse"}, done, 1'b0);
        chk({tag, " pass hold"}, pass_count, expq.size());
      end
    end
    #1 rst = 1'b0; start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pair_ready = 1'b0;
    ref_count = '0; nbr_count = '0;
    clear_mem();
    do_reset();
    @(negedge clk);
    chk("reset state", {busy, done, pair_valid, pass_count, ref_addr, nbr_addr, pair_ref, pair_nbr},
        '0);

    ref_mem[0] = pos(10, 0, 0); ref_mem[1] = pos(20, 0, 0);
    nbr_mem[0] = pos(10, 0, 0); nbr_mem[1] = pos(20, 0, 0);
    run_job("basic", 2, 2, 0, -1, 3);
    run_job("backpressure", 2, 2, 1, -1, -1);
    run_job("zero", 0, 5, 0, -1, -1);
    run_job("reset mid", 2, 2, 0, 5, -1);
    @(negedge clk);
    chk("after rst idle", {busy, done, pair_valid}, 3'b000);

    clear_mem();
    ref_mem[0] = pos(5, 3, 0); nbr_mem[0] = pos(5, 7, 0);
    run_job("tie y fwd", 1, 1, 0, -1, -1);
    nbr_mem[0] = pos(5, 1, 0);
    run_job("tie y back", 1, 1, 0, -1, -1);

    clear_mem();
    nbr_mem[0] = {64'd0, 32'h8000_0000};
    nbr_mem[1] = {64'd0, 32'hFFFF_FFFF};
    nbr_mem[2] = pos(0, 0, 1);
    run_job("sign edge", 1, 3, 0, -1, -1);

    for (int it = 0; it < 8; it++) begin
      int r, n;
      r = $urandom_range(1, 16);
      n = $urandom_range(1, 16);
      for (int a = 0; a < 16; a++) begin
        if ($urandom_range(0, 7) == 0) begin
          ref_mem[a] = {$urandom, $urandom, $urandom};
          nbr_mem[a] = {$urandom, $urandom, $urandom};
        end else begin
          ref_mem[a] = pos($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
          nbr_mem[a] = pos($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
        end
      end
      run_job("random", r, n, 2, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
